// File: rtl/matched_filter_correlator.sv
// matched_filter_correlator: streams frames of samples against a stored fingerprint and emits one dot-product score per frame
module matched_filter_correlator #(
  parameter int    SAMPLE_DATA_WIDTH       = 8,
  parameter int    MATCH_SCORE_WIDTH       = 32,
  parameter int    CAPTURE_LENGTH          = 1000,
  parameter string FINGERPRINT_MEMORY_FILE = "",
  localparam int   AW = (CAPTURE_LENGTH > 1) ? $clog2(CAPTURE_LENGTH) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                axiiv,
  input  logic signed [SAMPLE_DATA_WIDTH-1:0] axiid,
  output logic                                axiov,
  output logic signed [MATCH_SCORE_WIDTH-1:0] axiod,
  input  logic        [AW-1:0]                ram_write_addr,
  input  logic signed [SAMPLE_DATA_WIDTH-1:0] ram_write_data,
  input  logic                                ram_write_enable
);
  localparam int W = SAMPLE_DATA_WIDTH;
  localparam int S = MATCH_SCORE_WIDTH;
  localparam logic [AW-1:0] LAST = AW'(CAPTURE_LENGTH - 1);
  localparam logic [AW:0]   LEN  = (AW + 1)'(CAPTURE_LENGTH);
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state;
  logic [AW-1:0] k;
  logic signed [W-1:0] mem [CAPTURE_LENGTH];
  logic signed [W-1:0] s1_x, s1_fp;
  logic s1_v, s1_first, s1_last;
  logic signed [2*W-1:0] prod;
  logic p_v, p_first, p_last;
  logic signed [S-1:0] acc, prod_ext, acc_next;
  logic a_v, a_last;
  logic wr_ok;
  initial for (int i = 0; i < CAPTURE_LENGTH; i++) mem[i] = '0;
  assign wr_ok = ram_write_enable && ({1'b0, ram_write_addr} < LEN);
  always_ff @(posedge clk) begin
    if (wr_ok) mem[ram_write_addr] <= ram_write_data;
    s1_fp <= mem[k];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
    end else if (axiiv) begin
      state <= (k == LAST) ? IDLE : ACCUM;
      k     <= (k == LAST) ? '0 : k + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v     <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_x     <= '0;
    end else begin
      s1_v     <= axiiv;
      s1_first <= axiiv && (state == IDLE);
      s1_last  <= axiiv && (k == LAST);
      s1_x     <= axiid;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_v     <= 1'b0;
      p_first <= 1'b0;
      p_last  <= 1'b0;
      prod    <= '0;
    end else begin
      p_v     <= s1_v;
      p_first <= s1_first;
      p_last  <= s1_last;
      prod    <= s1_x * s1_fp;
    end
  end
  always_comb begin
    prod_ext = S'(prod);
    acc_next = p_v ? (p_first ? prod_ext : acc + prod_ext) : acc;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      a_v    <= 1'b0;
      a_last <= 1'b0;
    end else begin
      acc    <= acc_next;
      a_v    <= p_v;
      a_last <= p_v && p_last;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      axiov <= 1'b0;
      axiod <= '0;
    end else begin
      axiov <= a_v && a_last;
      axiod <= (a_v && a_last) ? acc : axiod;
    end
  end
endmodule

// File: tb/tb_matched_filter_correlator.sv
// tb_matched_filter_correlator: directed and random frames checked against a dot-product model
module tb_matched_filter_correlator;
   localparam int L = 4;
   localparam int W = 8;
   typedef int frame_t [L];
   logic clk = 1'b0, rst = 1'b1, axiiv = 1'b0, we = 1'b0;
   logic signed [W-1:0] axiid = '0, wd = '0;
   logic [1:0] wa = '0;
   logic axiov, axiov16;
   logic signed [31:0] axiod;
   logic signed [15:0] axiod16;
   int cyc = 0;
   int fp [L];
   int pq_cyc [$];
   longint pq_val [$], pq_val16 [$];
   logic pq_v16 [$];
   int eq_cyc [$];
   longint eq_val [$];
   int n_tests = 0, n_fail = 0;
   matched_filter_correlator #(.SAMPLE_DATA_WIDTH(W), .MATCH_SCORE_WIDTH(32), .CAPTURE_LENGTH(L)) dut (
      .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid), .axiov(axiov), .axiod(axiod),
      .ram_write_addr(wa), .ram_write_data(wd), .ram_write_enable(we));
   matched_filter_correlator #(.SAMPLE_DATA_WIDTH(W), .MATCH_SCORE_WIDTH(16), .CAPTURE_LENGTH(L)) dut16 (
      .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid), .axiov(axiov16), .axiod(axiod16),
      .ram_write_addr(wa), .ram_write_data(wd), .ram_write_enable(we));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk)
      if (axiov === 1'b1) begin
         pq_cyc.push_back(cyc);
         pq_val.push_back(axiod);
         pq_val16.push_back(axiod16);
         pq_v16.push_back(axiov16);
      end
   function automatic longint wrap(input longint v, input int w);
      return (v <<< (64 - w)) >>> (64 - w);
   endfunction
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic set_fp(input frame_t v);
      for (int i = 0; i < L; i++) begin
         we = 1'b1;
         wa = 2'(i);
         wd = W'(v[i]);
         step();
         fp[i] = v[i];
      end
      we = 1'b0;
   endtask
   task automatic play(input frame_t s, input int gmax, input bit expect_score = 1'b1,
                       input bit wr0 = 1'b0, input int wv = 0);
      longint sum = 0;
      for (int i = 0; i < L; i++) begin
         repeat ($urandom_range(gmax, 0)) step();
         axiiv = 1'b1;
         axiid = W'(s[i]);
         sum += longint'(s[i]) * longint'(fp[i]);
         if (i == 0 && wr0) begin
            we = 1'b1;
            wa = 2'd0;
            wd = W'(wv);
         end
         step();
         axiiv = 1'b0;
         if (i == 0 && wr0) begin
            we = 1'b0;
            fp[0] = wv;
         end
      end
      if (expect_score) begin
         eq_cyc.push_back(cyc + 3);
         eq_val.push_back(sum);
      end
   endtask
   task automatic check_pulses(input string tag);
      int n;
      repeat (6) step();
      chk({tag, ".count"}, pq_cyc.size(), eq_cyc.size());
      n = (pq_cyc.size() < eq_cyc.size()) ? pq_cyc.size() : eq_cyc.size();
      for (int i = 0; i < n; i++) begin
         chk({tag, ".cycle"}, pq_cyc[i], eq_cyc[i]);
         chk({tag, ".score32"}, pq_val[i], wrap(eq_val[i], 32));
         chk({tag, ".score16"}, pq_val16[i], wrap(eq_val[i], 16));
         chk({tag, ".valid16"}, 64'(pq_v16[i]), 64'd1);
      end
      pq_cyc.delete();
      pq_val.delete();
      pq_val16.delete();
      pq_v16.delete();
      eq_cyc.delete();
      eq_val.delete();
   endtask
   initial begin
      frame_t f, s;
      repeat (3) begin
         step();
         chk("reset.axiov", 64'(axiov), 64'd0);
         chk("reset.axiod", axiod, 64'd0);
         chk("reset.axiod16", axiod16, 64'd0);
      end
      rst = 1'b0;
      step();
      set_fp('{1, 1, 1, 1});
      play('{1, 2, 3, 4}, 0);
      check_pulses("basic");
      set_fp('{1, -1, 2, -2});
      play('{3, 1, -2, 4}, 0);
      check_pulses("signed");
      play('{3, 1, -2, 4}, 5);
      check_pulses("gaps");
      set_fp('{1, 1, 1, 1});
      play('{1, 1, 1, 1}, 0);
      play('{2, 2, 2, 2}, 0);
      check_pulses("b2b");
      chk("b2b.hold", axiod, 64'd8);
      set_fp('{-128, -128, -128, -128});
      play('{-128, -128, -128, -128}, 2);
      check_pulses("extreme");
      set_fp('{1, 1, 1, 1});
      play('{1, 1, 1, 1}, 0, 1'b1, 1'b1, 5);
      play('{1, 1, 1, 1}, 1);
      check_pulses("rdfirst");
      axiiv = 1'b1;
      axiid = 8'sd7;
      step();
      axiid = 8'sd9;
      step();
      axiiv = 1'b0;
      rst = 1'b1;
      repeat (3) begin
         step();
         chk("midrst.axiov", 64'(axiov), 64'd0);
         chk("midrst.axiod", axiod, 64'd0);
      end
      rst = 1'b0;
      step();
      set_fp('{1, 1, 1, 1});
      play('{3, 3, 3, 3}, 0, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_pulses("inflight");
      chk("inflight.axiod", axiod, 64'd0);
      play('{1, 2, 3, 4}, 0);
      check_pulses("postrst");
      for (int r = 0; r < 20; r++) begin
         if (r % 5 == 0) begin
            for (int i = 0; i < L; i++) f[i] = int'($urandom_range(255, 0)) - 128;
            set_fp(f);
         end
         for (int i = 0; i < L; i++) s[i] = int'($urandom_range(255, 0)) - 128;
         play(s, (r % 2 == 0) ? 0 : 3);
         if (r % 5 == 4) check_pulses("random");
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
